// File: rtl/icache_refill_pkg.sv
// icache_refill_pkg: AXI constants, line geometry and FSM encoding shared by the refill engine.
package icache_refill_pkg;
    localparam int BEATS = 16;
    localparam int CNT_W = 4;
    localparam logic [7:0] ARLEN = 8'(BEATS - 1);
    localparam logic [1:0] INCR = 2'b01;
    localparam logic [2:0] SIZE_4B = 3'b010;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;
endpackage

// File: rtl/icache_refill_wgen.sv
// icache_refill_wgen: formats one 32-bit beat into a masked 128-bit data-array write.
module icache_refill_wgen
    import icache_refill_pkg::*;
(
    input  logic [CNT_W-1:0] count,
    input  logic [31:0]      rdata,
    output logic [CNT_W-1:0] burst_count,
    output logic [127:0]     wdata,
    output logic [127:0]     wmask
);
    assign burst_count = count;
    assign wdata = {4{rdata}};
    assign wmask = {96'd0, 32'hffff_ffff} << {count[1:0], 5'd0};
endmodule

// File: rtl/icache_refill.sv
// icache_refill: fetches a 64-byte line with one 16-beat AXI INCR burst and streams it into the I-cache.
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int PADDR_W = 32,
    parameter int IDX_LEN = 7,
    parameter int BLK_LEN = 6,
    localparam int TAG_W = PADDR_W - IDX_LEN - BLK_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               miss_req_i,
    input  logic [PADDR_W-1:0] miss_addr_i,
    output logic               refill_busy_o,
    output logic               refill_done_o,
    output logic               refill_err_o,
    output logic [IDX_LEN-1:0] icache_index_o,
    output logic [3:0]         burst_count_o,
    output logic [127:0]       icache_line_wdata_o,
    output logic [127:0]       icache_wmask_o,
    output logic               icache_wen_o,
    output logic               tag_wen_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic               axi_arvalid_o,
    input  logic               axi_arready_i,
    output logic [PADDR_W-1:0] axi_araddr_o,
    output logic [7:0]         axi_arlen_o,
    output logic [2:0]         axi_arsize_o,
    output logic [1:0]         axi_arburst_o,
    input  logic               axi_rvalid_i,
    output logic               axi_rready_o,
    input  logic [31:0]        axi_rdata_i,
    input  logic [1:0]         axi_rresp_i,
    input  logic               axi_rlast_i
);
    localparam logic [PADDR_W-1:0] OFF_MASK = PADDR_W'((64'd1 << BLK_LEN) - 1);

    state_t state, state_nx;
    logic [PADDR_W-1:0] addr;
    logic [CNT_W:0] count;
    logic err_q, beat, sat, beat_bad;

    assign beat = state == R && axi_rvalid_i;
    assign sat = count == (CNT_W+1)'(BEATS);
    // A beat is bad if it reports an error, ends the burst early, or overruns it.
    assign beat_bad = axi_rresp_i != RESP_OKAY || (axi_rlast_i && count != (CNT_W+1)'(BEATS - 1)) || sat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            addr <= '0;
            count <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && miss_req_i) begin
                addr <= miss_addr_i & ~OFF_MASK;
                count <= '0;
                err_q <= 1'b0;
            end else if (beat) begin
                count <= sat ? count : count + 1'b1;
                err_q <= err_q | beat_bad;
            end
        end
    end

    always_comb begin
        state_nx = state;
        axi_arvalid_o = 1'b0;
        axi_rready_o = 1'b0;
        refill_done_o = 1'b0;
        refill_err_o = 1'b0;
        case (state)
            IDLE: state_nx = miss_req_i ? AR : IDLE;
            AR: begin
                axi_arvalid_o = 1'b1;
                state_nx = axi_arready_i ? R : AR;
            end
            R: begin
                axi_rready_o = 1'b1;
                state_nx = beat && axi_rlast_i ? DONE : R;
            end
            DONE: begin
                refill_done_o = !err_q;
                refill_err_o = err_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign refill_busy_o = state != IDLE;
    assign icache_wen_o = beat && !err_q && !beat_bad;
    assign tag_wen_o = refill_done_o;
    assign tag_o = addr[PADDR_W-1:BLK_LEN+IDX_LEN];
    assign icache_index_o = addr[BLK_LEN+IDX_LEN-1:BLK_LEN];
    assign axi_araddr_o = addr;
    assign axi_arlen_o = ARLEN;
    assign axi_arsize_o = SIZE_4B;
    assign axi_arburst_o = INCR;

    icache_refill_wgen u_wgen (
        .count       (count[CNT_W-1:0]),
        .rdata       (axi_rdata_i),
        .burst_count (burst_count_o),
        .wdata       (icache_line_wdata_o),
        .wmask       (icache_wmask_o)
    );
endmodule
